// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV M-extension multiply/divide unit with valid/ready handshakes on request and result.
// Latency: 1 cycle for divide-by-zero, signed overflow and cached REM; DATA_WIDTH/MUL_STEP+1 for multiply; DATA_WIDTH+1 for divide.
// Backpressure: the result is held in DONE until ready_i, and ready_o is high only in IDLE. Macro MULDIV_REMCACHE_EN enables the DIV->REM remainder cache.
module muldiv_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_STEP   = 4
) (
    input  logic                  clk,
    input  logic                  rstLow,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    input  logic [DATA_WIDTH-1:0] rs2_i,
    input  logic [2:0]            funct3_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] c_o,
    output logic                  busy_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] MUL_CYC = CW'(DATA_WIDTH / MUL_STEP - 1);
    localparam logic [CW-1:0] DIV_CYC = CW'(DATA_WIDTH - 1);
    localparam logic [W-1:0]  MIN_INT = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    // Latched operation: op code, sign fixups, the fixed operand and the shifting accumulator.
    logic [2:0]     op;
    logic           neg_q;      // quotient / product must be negated
    logic           neg_r;      // remainder takes the dividend sign
    logic [W-1:0]   opnd;       // multiplicand (mul) or divisor (div) magnitude
    logic [2*W-1:0] acc;        // {hi/rem, multiplier/quotient}
    logic [CW-1:0]  cnt;

    // Request decode, evaluated on the live inputs at accept time.
    logic           is_div, sgn1, sgn2, neg1, neg2;
    logic [W-1:0]   mag1, mag2;
    logic           div_zero, ovf, hit, fast, accept;
    logic [W-1:0]   fast_res;

    // Iteration datapath.
    logic [W+MUL_STEP-1:0]   pp, mul_sum;
    logic [2*W+MUL_STEP-1:0] mul_cat;
    logic [2*W-1:0]          mul_nxt, div_nxt, acc_nxt, prod;
    logic [W:0]              trial, diff;
    logic [W-1:0]            quo, rem, rem_fix, res_calc;

`ifdef MULDIV_REMCACHE_EN
    logic         cache_vld, cache_uns;
    logic [W-1:0] cache_rs1, cache_rs2, cache_rem, rs1_q, rs2_q;

    assign hit = cache_vld && (funct3_i[2:1] == 2'b11) && (funct3_i[0] == cache_uns)
              && (rs1_i == cache_rs1) && (rs2_i == cache_rs2);

    // Remainder cache: filled when a regular DIV/DIVU finishes, dropped on flush or any non-hitting accept.
    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            cache_vld <= 1'b0;
            cache_uns <= 1'b0;
            cache_rs1 <= '0;
            cache_rs2 <= '0;
            cache_rem <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
        end else if (flush_i) begin
            cache_vld <= 1'b0;
        end else if (accept) begin
            rs1_q <= rs1_i;
            rs2_q <= rs2_i;
            if (!hit) cache_vld <= 1'b0;
        end else if (state == CALC && cnt == '0 && op[2:1] == 2'b10) begin
            cache_vld <= 1'b1;
            cache_uns <= op[0];
            cache_rs1 <= rs1_q;
            cache_rs2 <= rs2_q;
            cache_rem <= rem_fix;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Operand signedness, magnitudes and the results that bypass iteration.
    always_comb begin
        is_div   = funct3_i[2];
        sgn1     = (funct3_i != 3'b011) && (funct3_i != 3'b101) && (funct3_i != 3'b111);
        sgn2     = (funct3_i == 3'b000) || (funct3_i == 3'b001)
                || (funct3_i == 3'b100) || (funct3_i == 3'b110);
        neg1     = sgn1 && rs1_i[W-1];
        neg2     = sgn2 && rs2_i[W-1];
        mag1     = neg1 ? -rs1_i : rs1_i;
        mag2     = neg2 ? -rs2_i : rs2_i;
        div_zero = is_div && (rs2_i == '0);
        ovf      = is_div && sgn2 && (rs1_i == MIN_INT) && (rs2_i == '1);
        fast     = div_zero || ovf || hit;
        fast_res = '0;
`ifdef MULDIV_REMCACHE_EN
        if (hit)           fast_res = cache_rem;
        else
`endif
        if (div_zero)      fast_res = funct3_i[1] ? rs1_i : '1;
        else if (ovf)      fast_res = funct3_i[1] ? '0 : rs1_i;
    end

    // One iteration step: MUL_STEP shift-add bits or one restoring-division bit, plus final sign fixup.
    always_comb begin
        pp = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (acc[j]) pp = pp + ({{MUL_STEP{1'b0}}, opnd} << j);
        end
        mul_sum  = {{MUL_STEP{1'b0}}, acc[2*W-1:W]} + pp;
        mul_cat  = {mul_sum, acc[W-1:0]};
        mul_nxt  = mul_cat[2*W+MUL_STEP-1:MUL_STEP];
        trial    = {acc[2*W-1:W], acc[W-1]};
        diff     = trial - {1'b0, opnd};
        div_nxt  = diff[W] ? {trial[W-1:0], acc[W-2:0], 1'b0}
                           : {diff[W-1:0],  acc[W-2:0], 1'b1};
        acc_nxt  = op[2] ? div_nxt : mul_nxt;
        prod     = neg_q ? -acc_nxt : acc_nxt;
        quo      = acc_nxt[W-1:0];
        rem      = acc_nxt[2*W-1:W];
        rem_fix  = neg_r ? -rem : rem;
        case (op)
            3'b000:         res_calc = prod[W-1:0];
            3'b100, 3'b101: res_calc = neg_q ? -quo : quo;
            3'b110, 3'b111: res_calc = rem_fix;
            default:        res_calc = prod[2*W-1:W];
        endcase
    end

    assign accept = (state == IDLE) && valid_i && !flush_i;

    // State register.
    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state and handshake outputs; flush overrides accept and drain.
    always_comb begin
        state_nxt = state;
        ready_o   = 1'b0;
        valid_o   = 1'b0;
        busy_o    = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) state_nxt = fast ? DONE : CALC;
            end
            CALC: begin
                busy_o = 1'b1;
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                busy_o  = 1'b1;
                valid_o = 1'b1;
                if (ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush_i) state_nxt = IDLE;
    end

    // Datapath: load on accept, iterate in CALC, register the result when entering DONE.
    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            op    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            opnd  <= '0;
            acc   <= '0;
            cnt   <= '0;
            c_o   <= '0;
        end else if (accept) begin
            op    <= funct3_i;
            neg_q <= neg1 ^ neg2;
            neg_r <= neg1;
            opnd  <= is_div ? mag2 : mag1;
            acc   <= {{W{1'b0}}, (is_div ? mag1 : mag2)};
            cnt   <= is_div ? DIV_CYC : MUL_CYC;
            if (fast) c_o <= fast_res;
        end else if (state == CALC && !flush_i) begin
            acc <= acc_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == '0) c_o <= res_calc;
        end
    end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: self-checking bench for muldiv_iter (DATA_WIDTH=32, MUL_STEP=4).
// Directed vector table, hand-written handshake/flush/reset sequences, then random ops vs an arithmetic model.
// Latency counts negedges after the accept edge until valid_o is seen high.
module tb_muldiv_iter;
    localparam int W = 32;
`ifdef MULDIV_REMCACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif
    localparam int LAT_MUL     = 9;
    localparam int LAT_DIV     = 33;
    localparam int LAT_REM_HIT = CACHE_ON ? 1 : 33;
    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3,
                           F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

    logic         clk = 1'b0;
    logic         rstLow, valid_i, ready_o, flush_i, valid_o, ready_i, busy_o;
    logic [W-1:0] rs1_i, rs2_i, c_o;
    logic [2:0]   funct3_i;

    int checks = 0;
    int failures = 0;

    muldiv_iter #(.DATA_WIDTH(W), .MUL_STEP(4)) dut (
        .clk(clk), .rstLow(rstLow), .valid_i(valid_i), .ready_o(ready_o),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .funct3_i(funct3_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .c_o(c_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Reference result straight from the M-extension arithmetic rules.
    function automatic logic [W-1:0] ref_res(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            F_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
            F_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            F_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            F_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
            F_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ov ? a : 32'(sa / sb);
            F_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            F_REM:    return (b == 0) ? a : ov ? 32'h0 : 32'(sa % sb);
            default:  return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge in IDLE; returns at the negedge after the accept edge.
    task automatic start_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        valid_i = 1'b1; funct3_i = f; rs1_i = a; rs2_i = b;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; funct3_i = 3'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output int lat);
        start_op(f, a, b);
        wait_valid(lat);
        res = c_o;
        drain();
    endtask

    vec_t         vt[$];
    logic [W-1:0] res;
    int           lat;
    bit           c_ok;
    logic [W-1:0] c_a, c_b;
    logic         c_uns;

    initial begin
        rstLow = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        rs1_i = '0; rs2_i = '0; funct3_i = '0;
        #1;
        check("reset ready_o", 32'(ready_o), 32'd1);
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset busy_o",  32'(busy_o),  32'd0);
        check("reset c_o",     c_o,          32'd0);
        @(negedge clk); @(negedge clk);
        rstLow = 1'b1;
        @(negedge clk);

        vt.push_back('{F_MUL,    32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, LAT_MUL});
        vt.push_back('{F_MULH,   32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, LAT_MUL});
        vt.push_back('{F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL});
        vt.push_back('{F_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT_MUL});
        vt.push_back('{F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_DIV});
        vt.push_back('{F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_REM_HIT});
        vt.push_back('{F_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1});
        vt.push_back('{F_REMU,   32'd5,         32'd0,         32'd5,         1});
        vt.push_back('{F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vt.push_back('{F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
        vt.push_back('{F_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1});
        vt.push_back('{F_MUL,    32'd6,         32'd7,         32'd42,        LAT_MUL});
        vt.push_back('{F_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, LAT_DIV});
        vt.push_back('{F_REMU,   32'hFFFF_FFFF, 32'd1,         32'd0,         LAT_REM_HIT});
        vt.push_back('{F_MULHU,  32'h8000_0000, 32'd2,         32'd1,         LAT_MUL});
        vt.push_back('{F_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_DIV});
        vt.push_back('{F_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         LAT_REM_HIT});
        // Remainder-cache sequence: hit, signedness mismatch, invalidation by MUL.
        vt.push_back('{F_DIV,    32'd100,       32'd7,         32'd14,        LAT_DIV});
        vt.push_back('{F_REM,    32'd100,       32'd7,         32'd2,         LAT_REM_HIT});
        vt.push_back('{F_DIV,    32'd100,       32'd7,         32'd14,        LAT_DIV});
        vt.push_back('{F_REMU,   32'd100,       32'd7,         32'd2,         LAT_DIV});
        vt.push_back('{F_DIV,    32'd100,       32'd7,         32'd14,        LAT_DIV});
        vt.push_back('{F_MUL,    32'd6,         32'd7,         32'd42,        LAT_MUL});
        vt.push_back('{F_REM,    32'd100,       32'd7,         32'd2,         LAT_DIV});

        for (int i = 0; i < vt.size(); i++) begin
            run_op(vt[i].f, vt[i].a, vt[i].b, res, lat);
            check($sformatf("vec%0d result", i),  res,      vt[i].exp);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
        end

        // Backpressure: result held, new requests ignored, then drained.
        start_op(F_DIVU, 32'd1000, 32'd7);
        wait_valid(lat);
        check("bp latency", 32'(lat), 32'(LAT_DIV));
        for (int i = 0; i < 10; i++) begin
            valid_i = 1'b1; funct3_i = F_MUL; rs1_i = 32'd3; rs2_i = 32'd3;
            @(negedge clk);
            check($sformatf("bp c_o stable %0d", i), c_o, 32'd142);
            check($sformatf("bp ready_o %0d", i), 32'(ready_o), 32'd0);
            check($sformatf("bp valid_o %0d", i), 32'(valid_o), 32'd1);
        end
        valid_i = 1'b0;
        drain();
        check("bp drained ready_o", 32'(ready_o), 32'd1);
        check("bp drained valid_o", 32'(valid_o), 32'd0);
        check("bp drained busy_o",  32'(busy_o),  32'd0);
        check("bp c_o kept",        c_o,          32'd142);

        // Flush during CALC cycle 5 of a divide.
        start_op(F_DIV, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush calc ready_o", 32'(ready_o), 32'd1);
        check("flush calc valid_o", 32'(valid_o), 32'd0);
        check("flush calc busy_o",  32'(busy_o),  32'd0);
        run_op(F_MUL, 32'd6, 32'd7, res, lat);
        check("post-flush mul", res, 32'd42);
        check("post-flush mul latency", 32'(lat), 32'(LAT_MUL));

        // Flush beats accept in IDLE.
        valid_i = 1'b1; flush_i = 1'b1; funct3_i = F_DIV; rs1_i = 32'd9; rs2_i = 32'd3;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        check("flush idle busy_o",  32'(busy_o),  32'd0);
        check("flush idle ready_o", 32'(ready_o), 32'd1);

        // Flush beats drain in DONE.
        start_op(F_DIVU, 32'd5, 32'd0);
        check("special valid_o", 32'(valid_o), 32'd1);
        ready_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0; flush_i = 1'b0;
        check("flush done valid_o", 32'(valid_o), 32'd0);
        check("flush done ready_o", 32'(ready_o), 32'd1);

        // Asynchronous reset in the middle of a divide.
        start_op(F_DIV, 32'd1000, 32'd3);
        repeat (3) @(negedge clk);
        #2 rstLow = 1'b0;
        #1;
        check("async rst busy_o",  32'(busy_o),  32'd0);
        check("async rst ready_o", 32'(ready_o), 32'd1);
        check("async rst valid_o", 32'(valid_o), 32'd0);
        check("async rst c_o",     c_o,          32'd0);
        @(negedge clk);
        rstLow = 1'b1;
        @(negedge clk);

        // Random operations against the arithmetic model, cache tracked from the request history.
        c_ok = 1'b0; c_a = '0; c_b = '0; c_uns = 1'b0;
        for (int i = 0; i < 200; i++) begin
            logic [2:0]   f;
            logic [W-1:0] a, b;
            bit           special, hitm;
            int           elat;
            f = 3'($urandom);
            a = pick_operand();
            b = pick_operand();
            special = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
            hitm = CACHE_ON && c_ok && (f[2:1] == 2'b11) && (a == c_a) && (b == c_b) && (f[0] == c_uns);
            elat = (special || hitm) ? 1 : (f[2] ? LAT_DIV : LAT_MUL);
            run_op(f, a, b, res, lat);
            check($sformatf("rnd%0d f=%0d a=%08h b=%08h result", i, f, a, b), res, ref_res(f, a, b));
            check($sformatf("rnd%0d latency", i), 32'(lat), 32'(elat));
            if (!hitm) begin
                c_ok  = (f[2:1] == 2'b10) && !special;
                c_a   = a;
                c_b   = b;
                c_uns = f[0];
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
Parametrised, iterative RV M-extension unit. Replaces the start/busy polling interface with a valid/ready handshake on both input and output. Width and multiplier radix are generic, and an output register holds each result until the consumer accepts it. Sits in the execution unit beside the ALU; driven by the issue logic and drained by writeback.

Parameters:
DATA_WIDTH, 32, operand/result width; even, >=8.
MUL_STEP, 4, multiplier bits retired per CALC cycle; must divide DATA_WIDTH.

Ports:
clk  in  1  clock, rising edge.
rstLow  in  1  reset; asynchronous, active-low.
valid_i  in  1  request valid.
ready_o  out  1  unit can accept a request.
rs1_i  in  DATA_WIDTH  multiplicand/dividend.
rs2_i  in  DATA_WIDTH  multiplier/divisor.
funct3_i  in  3  M-ext op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
flush_i  in  1  abort any in-flight or held operation.
valid_o  out  1  c_o holds a result.
ready_i  in  1  consumer accepts the result.
c_o  out  DATA_WIDTH  result.
busy_o  out  1  high in CALC or DONE.

Behaviour:
- Reset: state IDLE, ready_o=1, valid_o=0, busy_o=0, c_o=0, all internal registers 0.
- Accept: valid_i&ready_o at a rising edge. rs1_i, rs2_i and funct3_i are latched; the inputs are don't-care afterwards.
- Signedness per M spec: rs1 is signed for MUL, MULH, MULHSU, DIV, REM; rs2 is signed for MUL, MULH, DIV, REM. Signed operands are converted to magnitudes at accept; the result sign is applied when entering DONE.
- FSM: IDLE -> CALC on accept; CALC -> DONE when the iteration counter expires; DONE -> IDLE on ready_i&valid_o. Any state -> IDLE on flush_i.
- Special cases skip CALC (IDLE->DONE):
  - divisor 0: quotient all-ones, remainder = rs1.
  - signed overflow (rs1=MIN_INT, rs2=-1): DIV gives rs1, REM gives 0.
- Multiply: shift-add, MUL_STEP partial-product bits per cycle into a 2*DATA_WIDTH accumulator. CALC lasts DATA_WIDTH/MUL_STEP cycles. MUL returns the low half, MULH/MULHSU/MULHU the high half.
- Divide: restoring, one quotient bit per cycle, so CALC lasts DATA_WIDTH cycles. Quotient is negated when input signs differ; remainder takes the dividend sign.
- Latency (accept edge to first edge with valid_o=1): special case 1; MUL DATA_WIDTH/MUL_STEP+1; DIV DATA_WIDTH+1.
- ready_o=1 only in IDLE. No new request is accepted in the same cycle a result drains.
- Output: valid_o=1 only in DONE. c_o is registered and stable while valid_o&!ready_i (backpressure). c_o keeps its last value after draining.
- flush_i has priority over accept and over drain. The next cycle shows ready_o=1, valid_o=0, busy_o=0. Partial state is discarded.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous).

Optional Feature:
MULDIV_REMCACHE_EN.
- Defined: after a non-special DIV (DIVU), the unit keeps the remainder, operands and signedness in a cache register.
- A following REM (REMU) with identical operands and matching signedness goes IDLE->DONE with latency 1 and returns the cached remainder.
- The cache is invalidated by flush_i, reset, or any accepted MUL or mismatching request.
- Undefined: no cache register; REM always iterates.

Test Plan:
- DATA_WIDTH=32, MUL_STEP=4, MUL rs1=-3 (0xFFFFFFFD), rs2=7 -> valid_o on edge 9 after accept, c_o=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU rs1=-1, rs2=2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD on edge 33; REM -7/2 -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000 with latency 1.
- Backpressure: hold ready_i=0 for 10 cycles after valid_o -> c_o stable, ready_o=0, valid_i ignored; ready_i=1 -> IDLE next cycle.
- flush_i in CALC cycle 5 of a DIV -> next cycle ready_o=1, valid_o=0; following MUL 6x7 -> 42, uncorrupted.
- With MULDIV_REMCACHE_EN: DIV 100/7 (result 14) then REM 100/7 -> 2 with latency 1. REMU 100/7 after that DIV -> full 33-cycle latency, result 2.
